// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package loader_pkg;

   typedef enum logic [2:0] {
      LEN_HI,
      LEN_LO,
      DATA,
      CHK,
      DONE,
      ERR
   } state_t;

   localparam int HDR_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Big-endian 8->32 assembler: the first byte of a word ends up in bits [31:24].
module word_packer
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        byte_en,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_valid,
   output logic [1:0]  byte_idx
);

   logic [23:0] sh;

   // word is a separate register so it stays stable while the next word shifts in
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh         <= '0;
         byte_idx   <= '0;
         word       <= '0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= 1'b0;
         if (byte_en) begin
            sh       <= {sh[15:0], byte_in};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'(BYTES_PER_WORD - 1)) begin
               word       <= {sh, byte_in};
               word_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, XOR-checked byte stream, writes words
// to instruction memory and releases the CPU reset once the image is verified.
//
//   state  | meaning
//   LEN_HI | waiting for length high byte
//   LEN_LO | waiting for length low byte; range check
//   DATA   | receiving 4*N data bytes, words written as they complete
//   CHK    | waiting for the XOR checksum byte
//   DONE   | image verified, CPU released (terminal)
//   ERR    | overflow or checksum mismatch, CPU held (terminal)
module imem_loader
   import loader_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_rst,
   output logic              busy,
   output logic              done,
   output logic              err
);

   state_t            state, state_nxt;
   logic [7:0]        len_hi;
   logic [ADDR_W:0]   len_words;
   logic [ADDR_W:0]   wcnt;
   logic [7:0]        xor_acc;
   logic [ADDR_W-1:0] addr_q;
   logic [15:0]       n16;
   logic              len_over;
   logic              accept;
   logic              active;
   logic              byte_en;
   logic              last_byte_of_word;
   logic [1:0]        byte_idx;

   assign n16               = {len_hi, in_data};
   assign len_over          = {1'b0, n16} > (17'd1 << ADDR_W);
   assign accept            = in_valid & in_ready;
   assign byte_en           = accept && (state == DATA);
   assign last_byte_of_word = (byte_idx == 2'(BYTES_PER_WORD - 1));

   word_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .byte_en    (byte_en),
      .byte_in    (in_data),
      .word       (imem_wdata),
      .word_valid (imem_we),
      .byte_idx   (byte_idx)
   );

   always_comb begin
      state_nxt = state;
      active    = 1'b0;
      case (state)
         LEN_HI: begin
            active = 1'b1;
            if (accept) state_nxt = LEN_LO;
         end
         LEN_LO: begin
            active = 1'b1;
            if (accept) begin
               if (n16 == 16'd0)  state_nxt = CHK;
               else if (len_over) state_nxt = ERR;
               else               state_nxt = DATA;
            end
         end
         DATA: begin
            active = 1'b1;
            if (accept && last_byte_of_word && (wcnt == len_words - 1'b1))
               state_nxt = CHK;
         end
         CHK: begin
            active = 1'b1;
            if (accept) state_nxt = (in_data == xor_acc) ? DONE : ERR;
         end
         DONE:    state_nxt = DONE;
         ERR:     state_nxt = ERR;
         default: state_nxt = ERR;
      endcase
   end

   // in_ready is gated by rst so nothing is offered while the loader is held
   assign in_ready  = active & ~rst;
   assign busy      = active;
   assign done      = (state == DONE);
   assign err       = (state == ERR);
   assign cpu_rst   = (state != DONE);
   assign imem_addr = addr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= LEN_HI;
         len_hi    <= '0;
         len_words <= '0;
         wcnt      <= '0;
         xor_acc   <= '0;
         addr_q    <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            case (state)
               LEN_HI: len_hi <= in_data;
               LEN_LO: len_words <= n16[ADDR_W:0];
               DATA: begin
                  xor_acc <= xor_acc ^ in_data;
                  if (last_byte_of_word) begin
                     addr_q <= wcnt[ADDR_W-1:0];
                     wcnt   <= wcnt + 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
